// File: rtl/and_cell_sched_pkg.sv
// Shared definitions for the bit-serial AND-cell scheduler: state encoding and width helper.
package and_cell_sched_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EVAL = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_EVAL = ST_EVAL,
      S_RESP = ST_RESP
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/and_cell_scheduler_and2.sv
// Single-bit 2-input AND cell; the one shared evaluation resource of the scheduler.
module and2 (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = a & b;

endmodule

// File: rtl/and_cell_scheduler.sv
// Round-robin scheduler that pushes WIDTH-bit AND jobs from NREQ requesters through one
// shared single-bit cell, LSB first, SETTLE cycles per bit, and returns the tagged result.
module and_cell_scheduler
   import and_cell_sched_pkg::*;
#(
   parameter  int NREQ   = 4,
   parameter  int WIDTH  = 8,
   parameter  int SETTLE = 1,
   localparam int IDW    = clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_y,
   output logic                  busy
);

   localparam int BW = (WIDTH  > 1) ? clog2(WIDTH)  : 1;
   localparam int SW = (SETTLE > 1) ? clog2(SETTLE) : 1;
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SETTLE - 1);

   state_e           state_q,   state_d;
   logic [IDW-1:0]   ptr_q,     ptr_d;
   logic [IDW-1:0]   g_q,       g_d;
   logic [WIDTH-1:0] opa_q,     opa_d;
   logic [WIDTH-1:0] opb_q,     opb_d;
   logic [WIDTH-1:0] res_q,     res_d;
   logic [BW-1:0]    bitcnt_q,  bitcnt_d;
   logic [SW-1:0]    slotcnt_q, slotcnt_d;

   logic           gnt_found;
   logic [IDW-1:0] gnt_idx;
   logic           cell_a, cell_b, cell_y;

   // First valid requester at or after ptr, wrapping.
   always_comb begin
      logic [IDW-1:0] idx;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

   // Gated by rst_n so no accept strobe is shown on an edge where reset wins.
   assign req_ready = (rst_n && state_q == S_IDLE && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;

   assign cell_a = (state_q == S_EVAL) ? opa_q[bitcnt_q] : 1'b0;
   assign cell_b = (state_q == S_EVAL) ? opb_q[bitcnt_q] : 1'b0;

   and2 u_cell (
      .a (cell_a),
      .b (cell_b),
      .y (cell_y)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      g_d       = g_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      res_d     = res_q;
      bitcnt_d  = bitcnt_q;
      slotcnt_d = slotcnt_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               opa_d     = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
               opb_d     = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
               g_d       = gnt_idx;
               bitcnt_d  = '0;
               slotcnt_d = '0;
               state_d   = S_EVAL;
            end
         end
         S_EVAL: begin
            if (slotcnt_q == SLOT_LAST) begin
               res_d[bitcnt_q] = cell_y;
               slotcnt_d       = '0;
               bitcnt_d        = bitcnt_q + 1'b1;
               if (bitcnt_q == BIT_LAST) state_d = S_RESP;
            end else begin
               slotcnt_d = slotcnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               ptr_d   = (int'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         g_q       <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         res_q     <= '0;
         bitcnt_q  <= '0;
         slotcnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         g_q       <= g_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         res_q     <= res_d;
         bitcnt_q  <= bitcnt_d;
         slotcnt_q <= slotcnt_d;
      end
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_y     = res_q;
   assign rsp_id    = g_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_and_cell_scheduler.sv
// Directed bench for and_cell_scheduler: vector table of jobs plus backpressure, reset and SETTLE=3 sequences.
module tb_and_cell_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_y;
   logic        busy;

   logic [3:0]  s3_req_valid = '0;
   logic [3:0]  s3_req_ready;
   logic [31:0] s3_req_a = '0;
   logic [31:0] s3_req_b = '0;
   logic        s3_rsp_valid;
   logic        s3_rsp_ready = 1'b1;
   logic [1:0]  s3_rsp_id;
   logic [7:0]  s3_rsp_y;
   logic        s3_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_acc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   and_cell_scheduler #(.NREQ(4), .WIDTH(8), .SETTLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .busy(busy)
   );

   and_cell_scheduler #(.NREQ(4), .WIDTH(8), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(s3_req_valid), .req_ready(s3_req_ready), .req_a(s3_req_a), .req_b(s3_req_b),
      .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_id(s3_rsp_id), .rsp_y(s3_rsp_y),
      .busy(s3_busy)
   );

   typedef struct {
      logic        do_rst;
      logic        load;
      logic [3:0]  valid;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  gnt;
      logic [7:0]  y;
      int          gap;
   } vec_t;

   vec_t vt[12];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_job(input int k, input vec_t v);
      int n;
      logic [3:0] g;
      logic [1:0] eid;
      if (v.do_rst) do_reset();
      if (v.load) begin
         req_valid = v.valid;
         req_a = v.a;
         req_b = v.b;
      end
      rsp_ready = 1'b1;
      #1;
      n = 0;
      while (req_ready == 4'b0 && n < 30) begin
         @(posedge clk); #2; n++;
      end
      check($sformatf("v%0d grant", k), {28'b0, req_ready}, {28'b0, v.gnt});
      if (v.gap != 0) check($sformatf("v%0d accept spacing", k), cyc - last_acc, v.gap);
      last_acc = cyc;
      g = req_ready;
      eid = 2'd0;
      for (int i = 0; i < 4; i++) if (v.gnt[i]) eid = 2'(i);
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check($sformatf("v%0d latency", k), n, 8);
      check($sformatf("v%0d rsp_y", k), {24'b0, rsp_y}, {24'b0, v.y});
      check($sformatf("v%0d rsp_id", k), {30'b0, rsp_id}, {30'b0, eid});
      @(posedge clk); #1;
      check($sformatf("v%0d busy after handshake", k), {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      vt[0]  = '{1'b1, 1'b1, 4'b0001, 32'h000000F0, 32'h0000003C, 4'b0001, 8'h30, 0};
      vt[1]  = '{1'b1, 1'b1, 4'b1111, 32'hFFFFFFFF, 32'h88442211, 4'b0001, 8'h11, 0};
      vt[2]  = '{1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        4'b0010, 8'h22, 10};
      vt[3]  = '{1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        4'b0100, 8'h44, 10};
      vt[4]  = '{1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        4'b1000, 8'h88, 10};
      vt[5]  = '{1'b0, 1'b1, 4'b0010, 32'hC35AF00F, 32'hFF0FFF33, 4'b0010, 8'hF0, 0};
      vt[6]  = '{1'b0, 1'b1, 4'b1010, 32'hC35AF00F, 32'hFF0FFF33, 4'b1000, 8'hC3, 0};
      vt[7]  = '{1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        4'b0010, 8'hF0, 10};
      vt[8]  = '{1'b0, 1'b1, 4'b0101, 32'hC35AF00F, 32'hFF0FFF33, 4'b0100, 8'h0A, 0};
      vt[9]  = '{1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        4'b0001, 8'h03, 10};
      vt[10] = '{1'b0, 1'b1, 4'b1001, 32'hC35AF00F, 32'hFF0FFF33, 4'b1000, 8'hC3, 0};
      vt[11] = '{1'b0, 1'b1, 4'b0001, 32'h00000000, 32'hFFFFFFFF, 4'b0001, 8'h00, 0};

      do_reset();
      #1;
      check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("reset busy",      {31'b0, busy},      32'd0);
      check("reset req_ready", {28'b0, req_ready}, 32'd0);
      check("reset rsp_id",    {30'b0, rsp_id},    32'd0);
      check("reset rsp_y",     {24'b0, rsp_y},     32'd0);

      for (int k = 0; k < 12; k++) run_job(k, vt[k]);

      // Backpressure: response held while another request waits.
      req_valid = 4'b0001; req_a = 32'h003C005A; req_b = 32'h00F000FF; rsp_ready = 1'b1;
      #1;
      check("bp grant0", {28'b0, req_ready}, 32'h1);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      n = 0;
      while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
      rsp_ready = 1'b0; req_valid = 4'b0100;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("bp rsp_valid", {31'b0, rsp_valid}, 32'd1);
         check("bp rsp_y",     {24'b0, rsp_y},     32'h5A);
         check("bp rsp_id",    {30'b0, rsp_id},    32'd0);
         check("bp busy",      {31'b0, busy},      32'd1);
         check("bp req_ready", {28'b0, req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      check("bp req_ready before handshake", {28'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      check("bp grant after handshake", {28'b0, req_ready}, 32'h4);
      check("bp idle gap busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      check("bp accepted busy", {31'b0, busy}, 32'd1);
      n = 0;
      while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("bp second rsp_y",  {24'b0, rsp_y},  32'h30);
      check("bp second rsp_id", {30'b0, rsp_id}, 32'd2);
      @(posedge clk); #1;

      // Reset during EVAL bit 4 aborts the job and returns ptr to 0.
      req_valid = 4'b0100; req_a = 32'hFFFFFFFF; req_b = 32'h88442211;
      #1;
      check("rst grant2", {28'b0, req_ready}, 32'h4);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      repeat (4) @(posedge clk);
      #1;
      check("rst mid busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0; req_valid = 4'b1111;
      @(posedge clk); #1;
      check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst busy",      {31'b0, busy},      32'd0);
      check("rst req_ready", {28'b0, req_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst first grant", {28'b0, req_ready}, 32'h1);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      n = 0;
      while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("rst job rsp_y",  {24'b0, rsp_y},  32'h11);
      check("rst job rsp_id", {30'b0, rsp_id}, 32'd0);
      @(posedge clk); #1;

      // SETTLE=3 instance: 8 bits x 3 cycles.
      s3_req_valid = 4'b0001; s3_req_a = 32'h000000A5; s3_req_b = 32'h000000FF; s3_rsp_ready = 1'b1;
      #1;
      check("s3 grant", {28'b0, s3_req_ready}, 32'h1);
      @(posedge clk); #1;
      s3_req_valid = 4'b0000;
      n = 0;
      while (!s3_rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
      check("s3 latency", n, 24);
      check("s3 rsp_y",   {24'b0, s3_rsp_y},  32'hA5);
      check("s3 rsp_id",  {30'b0, s3_rsp_id}, 32'd0);
      @(posedge clk); #1;
      check("s3 busy after", {31'b0, s3_busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/and_cell_scheduler.md
# and_cell_scheduler

Bit-serial scheduler that shares one single-bit switch-level 2-input AND cell between NREQ requesters. Each accepted request carries WIDTH-bit operands. The block evaluates them through the shared cell one bit per slot, LSB first, and returns the WIDTH-bit result with the requester ID. It sits between requester logic and the gate-level cell and owns arbitration, operand sequencing and result assembly.

## Interface
Parameters:
- NREQ, 4: number of requesters; must be ≥2.
- WIDTH, 8: operand/result width in bits; must be ≥1.
- SETTLE, 1: cycles per bit slot before sampling cell output; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester request; must hold until accepted.
- req_ready  out  NREQ  one-hot accept strobe; at most one bit high.
- req_a  in  NREQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  clog2(NREQ)  index of requester that owns rsp_y.
- rsp_y  out  WIDTH  bitwise a AND b.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - Round-robin search of req_valid starting at pointer ptr; first valid index is grant g.
  - req_ready[g] is driven combinationally high in that cycle.
  - On that edge: latch req_a/req_b slices of g into opa/opb, latch g, clear bitcnt and slotcnt, go to EVAL.
  - With no valid request, stay in IDLE; req_ready stays all zero.
- EVAL:
  - Cell inputs are driven from opa[bitcnt] and opb[bitcnt]; slotcnt counts 0..SETTLE-1.
  - When slotcnt==SETTLE-1, sample the cell output into res[bitcnt], increment bitcnt and clear slotcnt.
  - After the sample of bit WIDTH-1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_y=res and rsp_id=g, both held stable.
  - On the edge with rsp_valid&&rsp_ready: ptr=(g+1) mod NREQ, go to IDLE.
- Outside EVAL, cell inputs are driven 0.
- req_valid is ignored outside IDLE. A requester deasserting valid before acceptance is a protocol violation and is not checked.
- No request acceptance in RESP; IDLE is always entered for at least one cycle between jobs.
- Reset values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, busy=0, res=0, cell inputs 0.
- Reset asserted mid-EVAL or mid-RESP aborts the job. No response is produced and ptr returns to 0 on the next edge.

## Timing
- T0 = acceptance edge (IDLE with req_ready[g]=1).
- Bit i is sampled at edge T0+(i+1)*SETTLE.
- rsp_valid rises after edge T0+WIDTH*SETTLE.
- Minimum request-to-request period: WIDTH*SETTLE+2 cycles, with rsp_ready tied high.
- rsp_valid, rsp_y and rsp_id are registered. req_ready is combinational from state, ptr and req_valid, with no dependence on rsp_ready.
- Backpressure: rsp_ready low holds RESP indefinitely with outputs constant.

## Structure
- Shared package and_cell_sched_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_EVAL=2'd1, ST_RESP=2'd2;
  - a clog2 helper function for rsp_id and counter widths.
- Sub-module: the team's switch-level cell and2 (a, b → y), instantiated once as the shared resource.
- Round-robin selection is a combinational function or always block inside the top level; no separate arbiter module.

## Test plan
- Single request, defaults: req_valid=4'b0001, a0=8'hF0, b0=8'h3C → req_ready=4'b0001 at T0; rsp_valid rises after T0+8; rsp_y=8'h30, rsp_id=0.
- All four valid after reset, rsp_ready=1, a_i=8'hFF, b_i=8'h11<<i (b0=8'h11, b1=8'h22, b2=8'h44, b3=8'h88) → grants in order 0,1,2,3; rsp_y = 8'h11, 8'h22, 8'h44, 8'h88; acceptance edges spaced 10 cycles apart.
- Round-robin skip: after servicing requester 1 (ptr=2), assert req_valid=4'b1010 → grant 3 first, then 1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while req_valid=4'b0100 → rsp_y and rsp_id stable, busy=1, req_ready=0 throughout; the request is accepted 1 cycle after the response handshake.
- Reset mid-op: drop rst_n low during EVAL bit 4 → next edge rsp_valid=0, busy=0, req_ready=0; ptr=0, so with all requesters valid the first grant after release is requester 0.
- SETTLE=3, WIDTH=8, a=8'hA5, b=8'hFF → each cell input pair is held 3 cycles; rsp_y=8'hA5 after edge T0+24.
